// File: rtl/io_regs_pkg.sv
// io_regs shared definitions: register offsets,
// STATUS bit positions and the TX drain FSM states.
package io_regs_pkg;

  localparam logic [31:0] IO_STATUS    = 32'h000;
  localparam logic [31:0] IO_BG_COLOR  = 32'h004;
  localparam logic [31:0] IO_UART_DATA = 32'h008;
  localparam logic [31:0] IO_IRQ_EN    = 32'h00C;
  localparam logic [31:0] IO_ERR_CLR   = 32'h010;
  localparam logic [31:0] IO_CYCLES    = 32'h014;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_RX_NONEMPTY = 1;
  localparam int ST_TX_IDLE     = 2;
  localparam int ST_RX_OVERRUN  = 3;
  localparam int ST_TX_OVERFLOW = 4;

  localparam logic [31:0] RX_EMPTY = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    SETTLE
  } tx_state_t;

endpackage

// File: rtl/io_regs_fifo.sv
// First-word-fall-through synchronous FIFO.
// A push on a full FIFO is taken only if a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_regs.sv
// System I/O register block: UART TX/RX FIFOs,
// background colour, sticky errors, cycle counter, IRQ.
module io_regs
  import io_regs_pkg::*;
#(
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int ADDR_BITS = 12
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        io_read_valid_i,
  input  logic        io_write_valid_i,
  input  logic [31:0] io_addr_i,
  input  logic [31:0] io_wdata_i,
  output logic [31:0] io_rdata_o,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_valid_o,
  input  logic        uart_tx_busy_i,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_valid_i,
  output logic        uart_rx_ready_o,
  output logic [23:0] bg_color_o,
  output logic        irq_o
);

  localparam int TLW = $clog2(TX_DEPTH) + 1;
  localparam int RLW = $clog2(RX_DEPTH) + 1;

  logic [31:0]  off;
  logic         wr_tx;
  logic         wr_bg;
  logic         wr_irq;
  logic         wr_clr;
  logic         rd_uart;

  logic [7:0]   tx_head;
  logic         tx_full;
  logic         tx_empty;
  logic [TLW-1:0] tx_level;
  logic         tx_pop;
  logic         tx_idle;

  logic [7:0]   rx_head;
  logic         rx_full;
  logic         rx_empty;
  logic [RLW-1:0] rx_level;
  logic         rx_pop;
  logic         rx_ready_q;

  logic         rx_ovr;
  logic         tx_ovf;
  logic         rx_ovr_set;
  logic         tx_ovf_set;
  logic [1:0]   irq_en;
  logic [23:0]  bg_color;
  logic [31:0]  cycles;
  logic [31:0]  status;
  logic [31:0]  rdata_nx;
  logic [31:0]  tx_lvl_w;
  logic [31:0]  rx_lvl_w;

  tx_state_t    state;
  tx_state_t    state_nx;

  logic         unused_bits;

  always_comb begin
    off = '0;
    off[ADDR_BITS-1:0] = io_addr_i[ADDR_BITS-1:0];
  end

  assign wr_tx   = io_write_valid_i && (off == IO_STATUS);
  assign wr_bg   = io_write_valid_i && (off == IO_BG_COLOR);
  assign wr_irq  = io_write_valid_i && (off == IO_IRQ_EN);
  assign wr_clr  = io_write_valid_i && (off == IO_ERR_CLR);
  assign rd_uart = io_read_valid_i && (off == IO_UART_DATA);
  assign rx_pop  = rd_uart && !rx_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (wr_tx),
    .pop     (tx_pop),
    .din     (io_wdata_i[7:0]),
    .dout    (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (rx_ready_q),
    .pop     (rx_pop),
    .din     (uart_rx_data_i),
    .dout    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // SETTLE gives the UART a cycle to raise busy
  always_comb begin
    state_nx = state;
    tx_pop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!tx_empty && !uart_tx_busy_i)
          state_nx = STROBE;
      end
      STROBE: begin
        tx_pop   = 1'b1;
        state_nx = SETTLE;
      end
      SETTLE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign uart_tx_valid_o = (state == STROBE);
  assign uart_tx_data_o  = uart_tx_valid_o ? tx_head : 8'h00;
  assign uart_rx_ready_o = rx_ready_q;
  assign bg_color_o      = bg_color;

  assign tx_idle = tx_empty && (state == IDLE)
                && !uart_tx_busy_i;

  assign tx_ovf_set = wr_tx && tx_full && !tx_pop;
  assign rx_ovr_set = rx_ready_q && rx_full && !rx_pop;

  assign tx_lvl_w = 32'(tx_level);
  assign rx_lvl_w = 32'(rx_level);

  always_comb begin
    status = '0;
    status[ST_TX_FULL]     = tx_full;
    status[ST_RX_NONEMPTY] = !rx_empty;
    status[ST_TX_IDLE]     = tx_idle;
    status[ST_RX_OVERRUN]  = rx_ovr;
    status[ST_TX_OVERFLOW] = tx_ovf;
    status[15:8]           = tx_lvl_w[7:0];
    status[23:16]          = rx_lvl_w[7:0];
  end

  always_comb begin
    rdata_nx = '0;
    unique case (1'b1)
      (off == IO_STATUS):   rdata_nx = status;
      (off == IO_BG_COLOR): rdata_nx = {8'h0, bg_color};
      (off == IO_UART_DATA): begin
        if (rx_empty) rdata_nx = RX_EMPTY;
        else          rdata_nx = {24'h0, rx_head};
      end
      (off == IO_IRQ_EN):   rdata_nx = {30'h0, irq_en};
      (off == IO_CYCLES):   rdata_nx = cycles;
      default:              rdata_nx = '0;
    endcase
  end

  // Error set wins over a same-cycle clear
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      io_rdata_o <= '0;
      rx_ready_q <= 1'b0;
      rx_ovr     <= 1'b0;
      tx_ovf     <= 1'b0;
      irq_en     <= '0;
      bg_color   <= '0;
      cycles     <= '0;
      irq_o      <= 1'b0;
    end else begin
      io_rdata_o <= rdata_nx;
      rx_ready_q <= uart_rx_valid_i && !rx_ready_q;
      rx_ovr <= (rx_ovr && !(wr_clr && io_wdata_i[3]))
             || rx_ovr_set;
      tx_ovf <= (tx_ovf && !(wr_clr && io_wdata_i[4]))
             || tx_ovf_set;
      if (wr_irq) irq_en   <= io_wdata_i[1:0];
      if (wr_bg)  bg_color <= io_wdata_i[23:0];
      cycles <= cycles + 32'd1;
      irq_o  <= (irq_en[0] && !rx_empty)
             || (irq_en[1] && tx_idle);
    end
  end

  assign unused_bits = ^{io_wdata_i, io_addr_i,
                         tx_lvl_w, rx_lvl_w};

endmodule

// File: tb/tb_io_regs.sv
// Directed self-checking bench for io_regs with a
// simple UART model driving busy after each strobe.
module tb_io_regs;

  localparam int TXD = 16;
  localparam int RXD = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        rd_v;
  logic        wr_v;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [23:0] bg;
  logic        irq;

  logic        force_busy;
  int          busy_cnt = 0;
  int          n_strobe = 0;
  logic [7:0]  cap [0:255];

  int checks = 0;
  int errors = 0;

  io_regs #(
    .TX_DEPTH  (TXD),
    .RX_DEPTH  (RXD),
    .ADDR_BITS (12)
  ) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .io_read_valid_i  (rd_v),
    .io_write_valid_i (wr_v),
    .io_addr_i        (addr),
    .io_wdata_i       (wdata),
    .io_rdata_o       (rdata),
    .uart_tx_data_o   (tx_data),
    .uart_tx_valid_o  (tx_valid),
    .uart_tx_busy_i   (tx_busy),
    .uart_rx_data_i   (rx_data),
    .uart_rx_valid_i  (rx_valid),
    .uart_rx_ready_o  (rx_ready),
    .bg_color_o       (bg),
    .irq_o            (irq)
  );

  always #5 clk_sys = ~clk_sys;

  assign tx_busy = force_busy || (busy_cnt != 0);

  always @(posedge clk_sys) begin
    if (tx_valid) begin
      busy_cnt <= 10;
      cap[n_strobe[7:0]] <= tx_data;
      n_strobe <= n_strobe + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic io_write(input logic [31:0] a,
                          input logic [31:0] d);
    wr_v  = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_v  = 1'b0;
  endtask

  task automatic io_read(input logic [31:0] a,
                         output logic [31:0] d);
    rd_v = 1'b1;
    addr = a;
    tick();
    rd_v = 1'b0;
    d    = rdata;
  endtask

  task automatic rx_inject(input logic [7:0] b);
    int n;
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    tick();
    while (!rx_ready && n < 5) begin
      tick();
      n++;
    end
    checks++;
    if (!rx_ready) begin
      errors++;
      $display("FAIL rx_accept: ready=%b required 1", rx_ready);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int target,
                              input int budget);
    for (int i = 0; i < budget && n_strobe < target; i++)
      tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({rdata, tx_valid, rx_ready, bg, irq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h txv=%b rxr=%b bg=%h irq=%b required all 0",
               rdata, tx_valid, rx_ready, bg, irq);
    end
    reset_n = 1'b1;
    addr = 32'h014;
    tick();
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("FAIL cycles_first: got %h required 0", rdata);
    end
    tick();
    checks++;
    if (rdata !== 32'd1) begin
      errors++;
      $display("FAIL cycles_second: got %h required 1", rdata);
    end
    begin
      logic [31:0] d;
      io_read(32'h000, d);
      checks++;
      if (d !== 32'h0000_0004) begin
        errors++;
        $display("FAIL reset_status: got %h required 00000004", d);
      end
    end
  endtask

  task automatic test_tx_latency();
    int base;
    base = n_strobe;
    io_write(32'h000, 32'h99);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL tx_lat_early: valid=%b required 0", tx_valid);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h99) begin
      errors++;
      $display("FAIL tx_lat: valid=%b data=%h required 1/99",
               tx_valid, tx_data);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b0 || n_strobe != base + 1) begin
      errors++;
      $display("FAIL tx_one_strobe: valid=%b strobes=%0d required 0/1",
               tx_valid, n_strobe - base);
    end
    repeat (15) tick();
  endtask

  task automatic test_tx_burst();
    int base;
    logic [31:0] d;
    base = n_strobe;
    io_write(32'h000, 32'h41);
    io_write(32'h000, 32'h42);
    io_write(32'h000, 32'h43);
    wait_strobes(base + 3, 100);
    checks++;
    if (n_strobe - base != 3) begin
      errors++;
      $display("FAIL burst_count: got %0d required 3",
               n_strobe - base);
    end
    checks++;
    if ({cap[base[7:0]], cap[8'(base + 1)], cap[8'(base + 2)]}
        !== 24'h414243) begin
      errors++;
      $display("FAIL burst_data: got %h %h %h required 41 42 43",
               cap[base[7:0]], cap[8'(base + 1)], cap[8'(base + 2)]);
    end
    repeat (15) tick();
    io_read(32'h000, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      errors++;
      $display("FAIL burst_idle: got %h required 00000004", d);
    end
  endtask

  task automatic test_tx_overflow();
    int base;
    int bad;
    logic [31:0] d;
    logic [31:0] exp;
    force_busy = 1'b1;
    tick();
    base = n_strobe;
    for (int i = 0; i <= TXD; i++)
      io_write(32'h000, 32'(i));
    exp = ((TXD % 256) << 8) | 32'h11;
    io_read(32'h000, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL ovf_status: got %h required %h", d, exp);
    end
    io_write(32'h010, 32'h10);
    io_read(32'h000, d);
    exp = ((TXD % 256) << 8) | 32'h01;
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL ovf_clear: got %h required %h", d, exp);
    end
    force_busy = 1'b0;
    wait_strobes(base + TXD, 400);
    checks++;
    if (n_strobe - base != TXD) begin
      errors++;
      $display("FAIL ovf_drain_count: got %0d required %0d",
               n_strobe - base, TXD);
    end
    bad = 0;
    for (int i = 0; i < TXD; i++)
      if (cap[8'(base + i)] !== 8'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ovf_drain_data: %0d wrong bytes required 0", bad);
    end
    repeat (15) tick();
  endtask

  task automatic test_rx();
    logic [31:0] d;
    rx_inject(8'h5A);
    rx_inject(8'hA5);
    io_read(32'h000, d);
    checks++;
    if (d !== 32'h0002_0006) begin
      errors++;
      $display("FAIL rx_status: got %h required 00020006", d);
    end
    io_read(32'h008, d);
    checks++;
    if (d !== 32'h0000_005A) begin
      errors++;
      $display("FAIL rx_first: got %h required 0000005a", d);
    end
    io_read(32'h008, d);
    checks++;
    if (d !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL rx_second: got %h required 000000a5", d);
    end
    io_read(32'h008, d);
    checks++;
    if (d !== 32'h8000_0000) begin
      errors++;
      $display("FAIL rx_empty: got %h required 80000000", d);
    end
  endtask

  task automatic test_rx_full_pushpop();
    logic [31:0] d;
    int bad;
    for (int i = 0; i < RXD; i++)
      rx_inject(8'(32'h20 + i));
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    tick();
    rd_v = 1'b1;
    addr = 32'h008;
    tick();
    rd_v = 1'b0;
    rx_valid = 1'b0;
    checks++;
    if (rdata !== 32'h0000_0020) begin
      errors++;
      $display("FAIL full_pp_head: got %h required 00000020", rdata);
    end
    io_read(32'h000, d);
    checks++;
    if (d !== ((32'(RXD % 256) << 16) | 32'h6)) begin
      errors++;
      $display("FAIL full_pp_status: got %h required %h",
               d, (32'(RXD % 256) << 16) | 32'h6);
    end
    bad = 0;
    for (int i = 1; i < RXD; i++) begin
      io_read(32'h008, d);
      if (d !== 32'(32'h20 + i)) bad++;
    end
    io_read(32'h008, d);
    if (d !== 32'h77) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_pp_order: %0d wrong bytes required 0", bad);
    end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    int bad;
    for (int i = 0; i <= RXD; i++)
      rx_inject(8'(32'h30 + i));
    io_read(32'h000, d);
    checks++;
    if (d !== ((32'(RXD % 256) << 16) | 32'hE)) begin
      errors++;
      $display("FAIL ovr_status: got %h required %h",
               d, (32'(RXD % 256) << 16) | 32'hE);
    end
    bad = 0;
    for (int i = 0; i < RXD; i++) begin
      io_read(32'h008, d);
      if (d !== 32'(32'h30 + i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ovr_data: %0d wrong bytes required 0", bad);
    end
    io_write(32'h010, 32'h08);
    io_read(32'h000, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      errors++;
      $display("FAIL ovr_clear: got %h required 00000004", d);
    end
  endtask

  task automatic test_irq_bg();
    logic [31:0] d;
    io_write(32'h00C, 32'h1);
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_idle: got %b required 0", irq);
    end
    rx_inject(8'h33);
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rx: got %b required 1", irq);
    end
    io_read(32'h00C, d);
    checks++;
    if (d !== 32'h1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_en_read: got %h irq=%b required 1/1", d, irq);
    end
    io_read(32'h008, d);
    tick();
    checks++;
    if (d !== 32'h33 || irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_pop: data=%h irq=%b required 33/0", d, irq);
    end
    io_write(32'h00C, 32'h2);
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_txidle: got %b required 1", irq);
    end
    io_write(32'h00C, 32'h0);
    io_write(32'h004, 32'h0012_3456);
    checks++;
    if (bg !== 24'h123456) begin
      errors++;
      $display("FAIL bg_set: got %h required 123456", bg);
    end
    io_read(32'h0000_1004, d);
    checks++;
    if (d !== 32'h0012_3456) begin
      errors++;
      $display("FAIL bg_alias_read: got %h required 00123456", d);
    end
    io_write(32'h004, 32'h0);
    checks++;
    if (bg !== 24'h0) begin
      errors++;
      $display("FAIL bg_zero: got %h required 000000", bg);
    end
    io_write(32'h020, 32'hFFFF_FFFF);
    io_read(32'h020, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL unmapped: got %h required 0", d);
    end
    io_read(32'h010, d);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL errclr_read: got %h irq=%b required 0/0", d, irq);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [31:0] d;
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++)
      io_write(32'h000, 32'(32'h60 + i));
    io_read(32'h000, d);
    checks++;
    if (d !== 32'h0000_0400) begin
      errors++;
      $display("FAIL mid_queued: got %h required 00000400", d);
    end
    base = n_strobe;
    force_busy = 1'b0;
    wait_strobes(base + 1, 20);
    reset_n = 1'b0;
    tick();
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_reset: valid=%b required 0", tx_valid);
    end
    tick();
    tick();
    reset_n = 1'b1;
    base = n_strobe;
    repeat (30) tick();
    checks++;
    if (n_strobe != base) begin
      errors++;
      $display("FAIL mid_no_strobe: got %0d required 0",
               n_strobe - base);
    end
    io_read(32'h000, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      errors++;
      $display("FAIL mid_status: got %h required 00000004", d);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    rd_v       = 1'b0;
    wr_v       = 1'b0;
    addr       = '0;
    wdata      = '0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    force_busy = 1'b0;
    repeat (3) tick();
    test_reset();
    test_tx_latency();
    test_tx_burst();
    test_tx_overflow();
    test_rx();
    test_rx_full_pushpop();
    test_rx_overrun();
    test_irq_bg();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
